// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock.
// Turns an unsigned IN_WIDTH-bit value into DIGITS packed BCD digits on number_32.
// number_32/overflow update only when a conversion completes (done pulse) or on reset,
// so a downstream display never shows intermediate values.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS   = 5
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [31:0]         number_32
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(IN_WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Add 3 to every digit >= 5; each nibble is independent (no carry between digits).
  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] bcd);
    logic [BW-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic                ovf_acc_q, ovf_acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overflow_q, overflow_d;
  logic [31:0]         number_q, number_d;

  logic [BW-1:0]       adj_s;
  logic [BW:0]         cat_s;
  logic                ovf_final_s;

  // Datapath for one double-dabble step: adjust digits, then shift {BCD, bin} left by one.
  always_comb begin
    adj_s       = add3_digits(bcd_q);
    cat_s       = {adj_s, bin_q[IN_WIDTH-1]};
    ovf_final_s = ovf_acc_q | cat_s[BW];
  end

  // Next-state and next-output logic for the IDLE/SHIFT controller.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    ovf_acc_d  = ovf_acc_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    number_d   = number_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          bcd_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          busy_d = 1'b0;
        end
      end
      SHIFT: begin
        bin_d     = bin_q << 1;
        bcd_d     = cat_s[BW-1:0];
        ovf_acc_d = ovf_final_s;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (ovf_final_s) begin
            // Saturate: all digits read F to flag an unrepresentable value.
            number_d   = 32'({BW{1'b1}});
            overflow_d = 1'b1;
          end else begin
            number_d   = 32'(cat_s[BW-1:0]);
            overflow_d = 1'b0;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset aborts any conversion.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      ovf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      number_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      ovf_acc_q  <= ovf_acc_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      number_q   <= number_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign number_32 = number_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: three instances cover the default
// configuration, DIGITS=4 (overflow), and IN_WIDTH=4/DIGITS=2 (full sweep).
module tb_bin_to_bcd_seq;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic [15:0] bin0 = 16'd0;
  logic [15:0] bin1 = 16'd0;
  logic [3:0]  bin2 = 4'd0;
  logic [2:0]  busy_v, done_v, ovf_v;
  logic [31:0] num0, num1, num2;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(5)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .bin_in(bin0),
    .busy(busy_v[0]), .done(done_v[0]), .overflow(ovf_v[0]), .number_32(num0));

  bin_to_bcd_seq #(.IN_WIDTH(16), .DIGITS(4)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .bin_in(bin1),
    .busy(busy_v[1]), .done(done_v[1]), .overflow(ovf_v[1]), .number_32(num1));

  bin_to_bcd_seq #(.IN_WIDTH(4), .DIGITS(2)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .bin_in(bin2),
    .busy(busy_v[2]), .done(done_v[2]), .overflow(ovf_v[2]), .number_32(num2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_in(input int sel, input logic s, input logic [15:0] v);
    case (sel)
      0: begin start_v[0] = s; bin0 = v; end
      1: begin start_v[1] = s; bin1 = v; end
      default: begin start_v[2] = s; bin2 = v[3:0]; end
    endcase
  endtask

  function automatic logic [31:0] num_of(input int sel);
    case (sel)
      0: return num0;
      1: return num1;
      default: return num2;
    endcase
  endfunction

  // One conversion: accept, scramble bin_in, wait for done (bounded), check
  // latency, busy duration, result, flag, and that done is a single pulse.
  task automatic convert(input int sel, input logic [15:0] v, input logic [31:0] exp_num,
                         input logic exp_ovf, input int exp_lat, input string tag);
    int n;
    int nbusy;
    set_in(sel, 1'b1, v);
    tick();
    set_in(sel, 1'b0, ~v);
    chk({tag, "_busy_after_accept"}, 32'(busy_v[sel]), 32'd1);
    n = 0;
    nbusy = 1;
    while (!done_v[sel] && n < 60) begin
      tick();
      n++;
      if (busy_v[sel]) nbusy++;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat));
    chk({tag, "_number"}, num_of(sel), exp_num);
    chk({tag, "_overflow"}, 32'(ovf_v[sel]), 32'(exp_ovf));
    chk({tag, "_busy_in_done"}, 32'(busy_v[sel]), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done_v[sel]), 32'd0);
    chk({tag, "_hold"}, num_of(sel), exp_num);
  endtask

  initial begin
    int n;
    logic [31:0] e;

    // Reset state
    tick();
    tick();
    chk("rst_num0", num0, 32'd0);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_ovf", 32'(ovf_v), 32'd0);
    reset_n = 1'b1;
    tick();

    // Default configuration
    convert(0, 16'd0, 32'h0000_0000, 1'b0, 16, "zero");
    convert(0, 16'd1234, 32'h0000_1234, 1'b0, 16, "v1234");
    convert(0, 16'd65535, 32'h0006_5535, 1'b0, 16, "v65535");

    // Four digits: boundary and overflow saturation
    convert(1, 16'd9999, 32'h0000_9999, 1'b0, 16, "d4_9999");
    convert(1, 16'd10000, 32'h0000_FFFF, 1'b1, 16, "d4_10000");
    convert(1, 16'd1, 32'h0000_0001, 1'b0, 16, "d4_1");

    // start held through busy, bin_in changed: single result, then back-to-back
    set_in(0, 1'b1, 16'd42);
    tick();
    bin0 = 16'd7;
    n = 0;
    while (!done_v[0] && n < 60) begin
      tick();
      n++;
    end
    chk("hold_lat", 32'(n), 32'd16);
    chk("hold_num", num0, 32'h0000_0042);
    tick();
    start_v[0] = 1'b0;
    chk("b2b_busy", 32'(busy_v[0]), 32'd1);
    n = 1;
    while (!done_v[0] && n < 60) begin
      tick();
      n++;
    end
    chk("b2b_spacing", 32'(n), 32'd17);
    chk("b2b_num", num0, 32'h0000_0007);
    tick();

    // Reset aborts a conversion in progress
    convert(0, 16'd500, 32'h0000_0500, 1'b0, 16, "v500");
    set_in(0, 1'b1, 16'd321);
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_done", 32'(done_v[0]), 32'd0);
    chk("abort_num", num0, 32'd0);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done_v[0]) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    convert(0, 16'd321, 32'h0000_0321, 1'b0, 16, "v321");

    // Small configuration sweep
    for (int v = 0; v < 16; v++) begin
      e = 32'(((v / 10) << 4) | (v % 10));
      convert(2, 16'(v), e, 1'b0, 4, $sformatf("w4_%0d", v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
